// File: rtl/key_pkg.sv
// Shared key-interface constants: default widths/depth and the game key codes.
package key_pkg;

  localparam int KEYS_DEF   = 9;
  localparam int CODE_W_DEF = 4;
  localparam int DEPTH_DEF  = 4;

  typedef enum logic [3:0] {
    KEY_UP    = 4'd0,
    KEY_DOWN  = 4'd1,
    KEY_LEFT  = 4'd2,
    KEY_RIGHT = 4'd3,
    KEY_A     = 4'd4,
    KEY_B     = 4'd5,
    KEY_SEL   = 4'd6,
    KEY_START = 4'd7,
    KEY_FIRE  = 4'd8
  } key_code_e;

endpackage

// File: rtl/key_fifo.sv
// DEPTH x W synchronous FIFO; head word is read straight from registered storage.
module key_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic [W-1:0]     head_data
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/key_cmd_queue.sv
// Turns one-cycle key press pulses into a queued stream of key codes,
// releasing simultaneous presses lowest index first.
module key_cmd_queue
  import key_pkg::*;
#(
  parameter int KEYS   = KEYS_DEF,
  parameter int CODE_W = CODE_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [KEYS-1:0]            key_p,
  input  logic                       cmd_ready,
  output logic                       cmd_valid,
  output logic [CODE_W-1:0]          cmd_code,
  output logic [$clog2(DEPTH):0]     cmd_count,
  output logic                       overflow
);

  logic [KEYS-1:0]   pending, grant_mask;
  logic [CODE_W-1:0] grant_idx;
  logic              grant_any, push_ok, pop, full, empty;

  assign cmd_valid = !empty;
  assign pop       = cmd_valid && cmd_ready;
  assign push_ok   = !full || pop;

  // Descending scan so the last hit is the lowest pending index.
  always_comb begin
    grant_idx = '0;
    grant_any = 1'b0;
    for (int i = KEYS - 1; i >= 0; i--) begin
      if (pending[i]) begin
        grant_idx = CODE_W'(i);
        grant_any = 1'b1;
      end
    end
  end

  assign grant_mask = (grant_any && push_ok) ? (KEYS'(1) << grant_idx) : '0;

  // A pulse on the bit being granted this cycle is a fresh event, not an overflow.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      pending  <= (pending & ~grant_mask) | key_p;
      overflow <= |(key_p & pending & ~grant_mask);
    end
  end

  key_fifo #(
    .DEPTH (DEPTH),
    .W     (CODE_W),
    .CNT_W ($clog2(DEPTH) + 1)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (grant_any && push_ok),
    .push_data (grant_idx),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .count     (cmd_count),
    .head_data (cmd_code)
  );

endmodule

// File: tb/tb_key_cmd_queue.sv
// Randomized and directed bench for key_cmd_queue against a queue-based model.
module tb_key_cmd_queue;

  localparam int KEYS = 9;
  localparam int CODE_W = 4;
  localparam int DEPTH = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic [KEYS-1:0]   key_p;
  logic              cmd_ready;
  logic              cmd_valid;
  logic [CODE_W-1:0] cmd_code;
  logic [2:0]        cmd_count;
  logic              overflow;

  always #5 clock = ~clock;

  key_cmd_queue #(.KEYS(KEYS), .CODE_W(CODE_W), .DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .key_p     (key_p),
    .cmd_ready (cmd_ready),
    .cmd_valid (cmd_valid),
    .cmd_code  (cmd_code),
    .cmd_count (cmd_count),
    .overflow  (overflow)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: a set of pending keys and an ordered queue of codes.
  logic [KEYS-1:0] m_pend;
  int              m_q[$];
  logic            m_ovf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = '0;
    m_q.delete();
    m_ovf = 1'b0;
  endtask

  task automatic compare_model();
    chk("cmd_valid", 32'(cmd_valid), 32'(m_q.size() > 0));
    chk("cmd_code",  32'(cmd_code),  (m_q.size() > 0) ? 32'(m_q[0]) : 32'd0);
    chk("cmd_count", 32'(cmd_count), 32'(m_q.size()));
    chk("overflow",  32'(overflow),  32'(m_ovf));
  endtask

  // Called at a falling edge: check current outputs, drive the next cycle, advance model.
  task automatic step(input logic [KEYS-1:0] kp, input logic rdy);
    bit              pop, full;
    int              g;
    logic [KEYS-1:0] gm;
    compare_model();
    key_p = kp;
    cmd_ready = rdy;
    pop  = (m_q.size() > 0) && rdy;
    full = (m_q.size() == DEPTH);
    g = -1;
    if (!full || pop)
      for (int i = 0; i < KEYS; i++)
        if (m_pend[i] && g < 0) g = i;
    gm = (g >= 0) ? (KEYS'(1) << g) : '0;
    m_ovf = |(kp & m_pend & ~gm);
    if (pop) void'(m_q.pop_front());
    if (g >= 0) m_q.push_back(g);
    m_pend = (m_pend & ~gm) | kp;
    @(negedge clock);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step('0, rdy);
  endtask

  initial begin
    reset = 1'b1;
    key_p = '0;
    cmd_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    chk("rst_valid", 32'(cmd_valid), 32'd0);
    chk("rst_code",  32'(cmd_code),  32'd0);
    chk("rst_count", 32'(cmd_count), 32'd0);
    chk("rst_ovf",   32'(overflow),  32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Single press, two-cycle latency.
    step(9'h008, 1'b1);
    chk("lat_t1_valid", 32'(cmd_valid), 32'd0);
    step('0, 1'b1);
    chk("lat_t2_valid", 32'(cmd_valid), 32'd1);
    chk("lat_t2_code",  32'(cmd_code),  32'd3);
    step('0, 1'b1);
    chk("lat_t3_count", 32'(cmd_count), 32'd0);
    idle(2, 1'b1);

    // Simultaneous presses released in ascending order.
    step(9'h121, 1'b0);
    idle(1, 1'b0);
    chk("multi_cnt1", 32'(cmd_count), 32'd1);
    idle(2, 1'b0);
    chk("multi_cnt3", 32'(cmd_count), 32'd3);
    chk("multi_head", 32'(cmd_code),  32'd0);
    step('0, 1'b1);
    chk("multi_2nd", 32'(cmd_code), 32'd5);
    idle(4, 1'b1);

    // Fill, overflow on a still-pending key, then one pop admits it.
    for (int i = 0; i < 5; i++) step(KEYS'(1) << i, 1'b0);
    idle(2, 1'b0);
    chk("full_cnt",  32'(cmd_count), 32'd4);
    chk("full_head", 32'(cmd_code),  32'd0);
    step(9'h010, 1'b0);
    chk("ovf_pulse", 32'(overflow), 32'd1);
    step('0, 1'b1);
    chk("ovf_clear", 32'(overflow), 32'd0);
    idle(2, 1'b0);
    chk("refill_cnt", 32'(cmd_count), 32'd4);
    idle(8, 1'b1);

    // Full FIFO with continuous pop and pulses every cycle.
    step(9'h1FF, 1'b0);
    idle(5, 1'b0);
    for (int i = 0; i < 20; i++) step(KEYS'($urandom_range(1, 511)), 1'b1);
    idle(30, 1'b1);

    // Re-press of key 2 in its own grant cycle is a new event.
    step(9'h004, 1'b1);
    step(9'h004, 1'b1);
    chk("regrant_ovf", 32'(overflow), 32'd0);
    step('0, 1'b0);
    chk("regrant_ovf2", 32'(overflow), 32'd0);
    idle(2, 1'b0);
    chk("regrant_cnt", 32'(cmd_count), 32'd2);
    idle(4, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic [KEYS-1:0] kp;
      kp = ($urandom_range(0, 3) == 0) ? KEYS'($urandom) : '0;
      step(kp, 1'(($urandom_range(0, 2) != 0)));
    end
    idle(20, 1'b1);

    // Asynchronous reset between edges with entries queued and pending nonzero.
    step(9'h00F, 1'b0);
    idle(3, 1'b0);
    chk("pre_rst_cnt", 32'(cmd_count), 32'd3);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", 32'(cmd_valid), 32'd0);
    chk("arst_count", 32'(cmd_count), 32'd0);
    chk("arst_code",  32'(cmd_code),  32'd0);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    idle(6, 1'b1);
    step(9'h100, 1'b0);
    idle(2, 1'b0);
    chk("post_rst_code", 32'(cmd_code), 32'd8);
    idle(3, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/key_cmd_queue.md
# key_cmd_queue

Consumer end of the debounced key-press pulse interface. Takes the 9-bit one-cycle press pulses produced by the key conditioning stage and turns them into a serialized stream of 4-bit key codes. Simultaneous presses are held in a pending mask and released lowest-index first into a small FIFO. The game control FSM reads the FIFO through a valid/ready handshake, so no press is lost while the FSM is busy.

## Interface
- KEYS, 9, number of key pulse lines; key index i maps to code i
- CODE_W, 4, code width; must satisfy 2^CODE_W >= KEYS
- DEPTH, 4, FIFO entries; power of two, at least 2
- clock  input  1  system clock, single clock domain
- reset  input  1  asynchronous, active-high; clears all state
- key_p  input  KEYS  one-cycle press pulses, synchronous to clock; several bits may be high at once
- cmd_ready  input  1  consumer accepts the head code this cycle
- cmd_valid  output  1  FIFO non-empty; head code present
- cmd_code  output  CODE_W  head key code; 0 when cmd_valid=0
- cmd_count  output  $clog2(DEPTH)+1  number of entries in the FIFO
- overflow  output  1  one-cycle pulse: a press was merged into an already-pending press of the same key

## Operation
- Reset values: pending=0, FIFO empty, cmd_valid=0, cmd_code=0, cmd_count=0, overflow=0.
- pending[KEYS-1:0] is a registered mask. Each cycle, grant = lowest set bit of pending, or none.
- A grant is issued only when push is allowed: FIFO not full, or FIFO full with a pop in the same cycle.
- Push on grant: write the binary index of the granted bit to the FIFO tail, and clear that bit.
- pending_next = (pending & ~grant_mask) | key_p.
- A pulse on a bit being granted in the same cycle re-sets that bit as a new event. No overflow.
- overflow_next = |(key_p & pending & ~grant_mask). It is registered, high for one cycle.
- Pop: cmd_valid && cmd_ready at the clock edge. cmd_ready is ignored when empty.
- Simultaneous push and pop: count unchanged. When full this is allowed.
- With the FIFO full and no pop, pending holds its bits. Presses remain queued in the mask, at most one per key.
- Pointers wrap modulo DEPTH. Full/empty are decided by cmd_count, not by pointer equality alone.
- The block has no state machine beyond the FIFO and the pending mask. The grant is combinational from registered pending and FIFO status.
- reset asserted mid-operation: all contents are discarded immediately (asynchronous). Outputs take reset values without waiting for a clock edge.

## Timing
- key_p high in cycle t: the pending bit is set at the end of t.
- Grant and push happen in t+1. cmd_valid=1 and cmd_code are valid in t+2, with 2-cycle latency to an empty, idle queue.
- N simultaneous pulses into an empty queue: codes enter on N consecutive cycles, ascending index, one per cycle.
- Throughput: one push and one pop per cycle sustained.
- cmd_code and cmd_valid are registered FIFO head outputs. They change only at clock edges or on reset.
- overflow is asserted in the cycle after the offending key_p pulse.

## Structure
- Shared package key_pkg holds KEYS, CODE_W and DEPTH defaults, plus the key code constants for the game (e.g. KEY_UP=0 ... KEY_FIRE=8). The game FSM and this block share these.
- One sub-module, key_fifo: a synchronous DEPTH x CODE_W FIFO with push, pop, full, empty and count. It uses asynchronous active-high reset.
- The top level holds the pending mask, the priority encoder and the overflow logic.

## Test plan
- Reset, then key_p=9'h008 for one cycle, cmd_ready=1 -> cmd_valid high exactly 2 cycles later with cmd_code=3 for one cycle; cmd_count returns to 0.
- key_p=9'h121 (keys 0, 5, 8) in one cycle, cmd_ready=0 -> cmd_count reaches 3 on consecutive cycles. Then cmd_ready=1 -> codes 0, 5, 8 in order.
- cmd_ready=0, pulse keys 0..4 on separate cycles (DEPTH=4) -> count=4 with codes 0..3; pending holds bit 4. Pulse key 4 again -> overflow for one cycle. One pop -> code 4 enters the FIFO and count stays at 4.
- FIFO full with cmd_ready=1 continuously and new pulses every cycle -> push and pop in the same cycle, count stays 4, no code lost or duplicated.
- Key 2 pulsed in the same cycle its pending bit is granted -> two code-2 entries, overflow stays 0.
- reset asserted between clock edges with 3 entries queued and pending nonzero -> cmd_valid, cmd_count and cmd_code go to 0 immediately. After release there is no output until new key_p.
